dm_resp_ctrl: RTL and testbench

- Data-memory responder sitting at the far end of the MEM-stage load/store port.
- Accepts the MEM stage's request: rd/wr strobes, byte address, active-low byte write mask, pre-aligned write data and access type.
- Performs the access against an internal word-organised SRAM with configurable latency and returns the raw 32-bit word; byte/half extraction and sign extension stay in MEM.
- Drives a stall to the hazard unit so MEM/WB is held until the access completes; flags misaligned and out-of-range accesses.

---
 rtl/cpu_def_pkg.sv | 33 +++
 rtl/dm_resp_ctrl_sram.sv | 44 ++++
 rtl/dm_resp_ctrl.sv | 140 ++++++++++++++
 tb/tb_dm_resp_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_def_pkg.sv
// Shared CPU definitions: access types, responder FSM states,
// data widths and the access alignment rule.
package cpu_def_pkg;

  localparam int DATA_BITS = 32;
  localparam int WEB_BITS  = 4;

  typedef enum logic [2:0] {
    BYTE    = 3'b000,
    HWORD   = 3'b001,
    WORD    = 3'b010,
    BYTE_U  = 3'b100,
    HWORD_U = 3'b101
  } access_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  function automatic logic misaligned(
    input logic [2:0] t,
    input logic [1:0] a
  );
    logic w, h;
    w = (t == WORD) && (a != 2'b00);
    h = ((t == HWORD) || (t == HWORD_U))
        && (a == 2'b11);
    return w | h;
  endfunction

endpackage

// File: rtl/dm_resp_ctrl_sram.sv
// Single-port word SRAM: byte-masked synchronous write,
// registered read output.
module dm_sram_array
  import cpu_def_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        idx_i,
  input  logic [WEB_BITS-1:0]  web_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int k = 0; k < WEB_BITS; k++) begin
        if (!web_i[k])
          mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i)
      rdata_d = mem[idx_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_resp_ctrl.sv
// MEM-stage data memory responder: serialises one access at a
// time against the SRAM, stalls the pipeline and flags faults.
module dm_resp_ctrl
  import cpu_def_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [3:0]  dm_web_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [2:0]  cputype_i,
  output logic [31:0] dm_rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  web_q, web_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic        rz_q, rz_d;

  logic        req, idle, last, fault;
  logic [31:0] f_addr, f_wdata;
  logic [3:0]  f_web;
  logic [2:0]  f_type;
  logic        f_wr;
  logic [31:0] sram_rdata;

  // With LAT=1 the final cycle is the IDLE cycle itself, so the
  // live inputs stand in for the not-yet-captured request.
  always_comb begin
    req     = dm_rd_i | dm_wr_i;
    idle    = (state_q == IDLE);
    f_addr  = idle ? dm_addr_i  : addr_q;
    f_web   = idle ? dm_web_i   : web_q;
    f_wdata = idle ? dm_wdata_i : wdata_q;
    f_type  = idle ? cputype_i  : type_q;
    f_wr    = idle ? dm_wr_i    : wr_q;
    last    = (idle && req && (LAT == 1))
           || (state_q == BUSY && cnt_q == 4'd1);
    fault   = misaligned(f_type, f_addr[1:0])
           || (f_addr[31:2] >= 30'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    web_d   = web_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = dm_addr_i;
          web_d   = dm_web_i;
          wdata_d = dm_wdata_i;
          type_d  = cputype_i;
          wr_d    = dm_wr_i;
          if (LAT == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = last && fault;
    rz_d  = rz_q;
    if (last && !f_wr)
      rz_d = fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      web_q   <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      web_q   <= web_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rz_q    <= rz_d;
    end
  end

  dm_sram_array #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (last && !fault),
    .we_i    (f_wr),
    .idx_i   (f_addr[AW+1:2]),
    .web_i   (f_web),
    .wdata_i (f_wdata),
    .rdata_o (sram_rdata)
  );

  assign stall_o    = !rst
                   && ((idle && req) || state_q == BUSY);
  assign err_o      = err_q;
  assign dm_rdata_o = rz_q ? 32'h0 : sram_rdata;

endmodule

// File: tb/tb_dm_resp_ctrl.sv
// Self-checking bench for dm_resp_ctrl against a word-array
// reference model with directed and random accesses.
module tb_dm_resp_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_rd_i = 1'b0;
  logic        dm_wr_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [3:0]  dm_web_i = 4'hF;
  logic [31:0] dm_wdata_i = '0;
  logic [2:0]  cputype_i = '0;
  logic [31:0] dm_rdata_o;
  logic        stall_o;
  logic        err_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] exp_rd = '0;
  logic [2:0]  tys [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  dm_resp_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .dm_rd_i    (dm_rd_i),
    .dm_wr_i    (dm_wr_i),
    .dm_addr_i  (dm_addr_i),
    .dm_web_i   (dm_web_i),
    .dm_wdata_i (dm_wdata_i),
    .cputype_i  (cputype_i),
    .dm_rdata_o (dm_rdata_o),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a,
                                  input logic [2:0] t);
    int lo;
    lo = int'(a % 4);
    if (t == 3'b010 && lo != 0) return 1'b1;
    if ((t == 3'b001 || t == 3'b101) && lo == 3) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_in();
    dm_rd_i = 1'b0;
    dm_wr_i = 1'b0;
  endtask

  // Random traffic on the port while the responder is not in IDLE
  task automatic garbage();
    dm_rd_i    = 1'($urandom);
    dm_wr_i    = 1'($urandom);
    dm_addr_i  = $urandom;
    dm_web_i   = 4'($urandom);
    dm_wdata_i = $urandom;
    cputype_i  = 3'($urandom);
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr,
                        input logic [3:0] web,
                        input logic [31:0] wd,
                        input logic [2:0] ty);
    bit flt;
    @(negedge clk);
    dm_rd_i = rd; dm_wr_i = wr; dm_addr_i = addr;
    dm_web_i = web; dm_wdata_i = wd; cputype_i = ty;
    #1 chk("stall_req", 32'(stall_o), 32'd1);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      garbage();
      #1 chk("stall_busy", 32'(stall_o), 32'd1);
    end
    flt = is_fault(addr, ty);
    if (wr) begin
      if (!flt)
        for (int k = 0; k < 4; k++)
          if (!web[k]) mem[addr / 4][8*k +: 8] = wd[8*k +: 8];
    end else begin
      exp_rd = flt ? 32'h0 : mem[addr / 4];
    end
    @(negedge clk);
    garbage();
    #1;
    chk("stall_done", 32'(stall_o), 32'd0);
    chk("err_done", 32'(err_o), 32'(flt));
    chk("rdata_done", dm_rdata_o, exp_rd);
  endtask

  initial begin
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", dm_rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 16; w++)
      access(1'b0, 1'b1, 32'(w * 4), 4'h0, $urandom, 3'b010);

    access(1'b0, 1'b1, 32'h10, 4'h0, 32'hDEADBEEF, 3'b010);
    access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 3'b010);
    chk("word_rd", dm_rdata_o, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h11, 4'b1101, 32'h0000AA00, 3'b000);
    access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 3'b010);
    chk("byte_merge", dm_rdata_o, 32'hDEADAAEF);
    access(1'b0, 1'b1, 32'h13, 4'h0, 32'h11112222, 3'b001);
    access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 3'b010);
    chk("mis_nowrite", dm_rdata_o, 32'hDEADAAEF);
    access(1'b1, 1'b0, 32'(DEPTH * 4), 4'hF, 32'h0, 3'b010);
    chk("oor_zero", dm_rdata_o, 32'h0);
    access(1'b0, 1'b1, 32'h13, 4'hF, 32'h0, 3'b101);
    chk("wr_keeps_rd", dm_rdata_o, 32'h0);

    // reset in the middle of a store
    @(negedge clk);
    dm_rd_i = 1'b0; dm_wr_i = 1'b1; dm_addr_i = 32'h20;
    dm_web_i = 4'h0; dm_wdata_i = 32'h12345678;
    cputype_i = 3'b010;
    #1 chk("rs_stall0", 32'(stall_o), 32'd1);
    @(negedge clk);
    idle_in();
    rst = 1'b1;
    #1;
    chk("rs_stall", 32'(stall_o), 32'd0);
    chk("rs_err", 32'(err_o), 32'd0);
    chk("rs_rdata", dm_rdata_o, 32'd0);
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 3'b010);

    access(1'b1, 1'b1, 32'h30, 4'h0, 32'h5, 3'b010);
    access(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 3'b010);
    chk("both_wr", dm_rdata_o, 32'h5);
    for (int i = 0; i < 3; i++)
      access(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'h0, 3'b010);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic        wr;
      a  = ($urandom_range(7) == 0)
           ? 32'(DEPTH * 4) + 32'($urandom_range(255))
           : 32'($urandom_range(63));
      wr = 1'($urandom);
      access(wr ? 1'($urandom) : 1'b1, wr, a, 4'($urandom),
             $urandom, tys[$urandom_range(4)]);
    end

    @(negedge clk);
    idle_in();
    #1 chk("end_stall", 32'(stall_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
